// File: rtl/pwm_fade_if.sv
// Target handshake and level/status bundle between the decoder logic and the
// fade controller.
//
// Handshake: a target is transferred at the rising clock edge where both
// load (valid) and ready are 1. target_r/g/b are sampled only at that edge.
// The master may raise load at any time and is not required to hold it.
// A load seen while ready=0 is dropped, not queued. ready/busy/done and the
// level_* outputs are registered and have no combinational path from the inputs.
interface pwm_fade_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] target_r;
  logic [WIDTH-1:0] target_g;
  logic [WIDTH-1:0] target_b;
  logic             load;
  logic             ready;
  logic [WIDTH-1:0] level_r;
  logic [WIDTH-1:0] level_g;
  logic [WIDTH-1:0] level_b;
  logic             busy;
  logic             done;

  modport master (
    output target_r, target_g, target_b, load,
    input  ready, level_r, level_g, level_b, busy, done
  );

  modport slave (
    input  target_r, target_g, target_b, load,
    output ready, level_r, level_g, level_b, busy, done
  );
endinterface

// File: rtl/pwm_fade_controller.sv
// RGB fade sequencer: accepts a colour target, then walks the three PWM level
// buses toward it one LSB per ramp step. Levels only change on the edge where
// the frame counter wraps, so every PWM period runs with a single level.
module pwm_fade_controller #(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  pwm_fade_if.slave  bus,
  output logic       dbg_state_o   // 1 while ramping
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t           state_q;
  logic             ready_q, busy_q, done_q;
  logic [WIDTH-1:0] frame_cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [WIDTH-1:0] level_r_q, level_g_q, level_b_q;
  logic [WIDTH-1:0] tgt_r_q, tgt_g_q, tgt_b_q;
  logic [WIDTH-1:0] level_r_d, level_g_d, level_b_d;
  logic             frame_end, step, accept, tgt_match, all_eq_d;

  // One LSB toward the target, or hold when already there.
  function automatic logic [WIDTH-1:0] toward(input logic [WIDTH-1:0] lv,
                                              input logic [WIDTH-1:0] tg);
    if (lv < tg)      return lv + 1'b1;
    else if (lv > tg) return lv - 1'b1;
    else              return lv;
  endfunction

  assign frame_end = (frame_cnt_q == '1);
  assign step      = frame_end && (div_q == DIV_LAST);
  assign accept    = bus.load && ready_q;
  assign tgt_match = (bus.target_r == level_r_q) && (bus.target_g == level_g_q) &&
                     (bus.target_b == level_b_q);

  // Candidate levels for the next ramp step and whether that step finishes.
  always_comb begin
    level_r_d = toward(level_r_q, tgt_r_q);
    level_g_d = toward(level_g_q, tgt_g_q);
    level_b_d = toward(level_b_q, tgt_b_q);
    all_eq_d  = (level_r_d == tgt_r_q) && (level_g_d == tgt_g_q) && (level_b_d == tgt_b_q);
  end

  // Free-running frame counter (in phase with the pwm counters) and the
  // step divider, which restarts on every accepted target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      div_q       <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
      if (accept)
        div_q <= '0;
      else if (frame_end)
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // Control FSM with registered ready/busy/done and the level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      level_r_q <= '0;
      level_g_q <= '0;
      level_b_q <= '0;
      tgt_r_q   <= '0;
      tgt_g_q   <= '0;
      tgt_b_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            tgt_r_q <= bus.target_r;
            tgt_g_q <= bus.target_g;
            tgt_b_q <= bus.target_b;
            if (tgt_match) begin
              // Nothing to ramp: report completion straight away.
              done_q <= 1'b1;
            end else begin
              state_q <= RAMP;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (step) begin
            level_r_q <= level_r_d;
            level_g_q <= level_g_d;
            level_b_q <= level_b_d;
            if (all_eq_d) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.level_r = level_r_q;
  assign bus.level_g = level_g_q;
  assign bus.level_b = level_b_q;
  assign dbg_state_o = (state_q == RAMP);

endmodule

// File: doc/pwm_fade_controller.md
# pwm_fade_controller

Sequencer for the three-channel RGB PWM datapath. It accepts a new colour target (R, G, B levels) over a valid/ready handshake. It then ramps the three `level` buses that feed the `pwm` instances toward that target, one LSB per step. Level changes occur only at PWM period boundaries, so no period is ever truncated or glitched. It sits between the user-input/decoder logic and the three `pwm` channels.

## Interface
Parameters:
- `WIDTH`, 8, level width; must match the `pwm` instances. The PWM period is 2^WIDTH cycles.
- `STEP_DIV`, 4, number of PWM periods per ramp step. Must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `target_r`, `target_g`, `target_b`  in  WIDTH each  requested levels; sampled only on handshake.
- `load`  in  1  target valid.
- `ready`  out  1  high when a new target can be accepted.
- `level_r`, `level_g`, `level_b`  out  WIDTH each  registered levels to the `pwm` `level` inputs.
- `busy`  out  1  ramp in progress.
- `done`  out  1  one-cycle pulse when the levels reach the target.

## Operation
- Frame counter `frame_cnt` is WIDTH bits, free-running, +1 per cycle, wraps at 2^WIDTH−1 → 0.
  - `frame_end` = (`frame_cnt` == 2^WIDTH−1).
  - The counter is aligned with the `pwm` counters when both leave reset together.
- Divider `div`: counts `frame_end` events from 0 to STEP_DIV−1. `step` = `frame_end` && (`div` == STEP_DIV−1).
- States:
  - IDLE: `ready`=1, `busy`=0.
  - RAMP: `ready`=0, `busy`=1.
- IDLE, `load` && `ready`:
  - Latch the three targets into internal registers.
  - If all targets already equal the current levels: stay in IDLE and pulse `done` next cycle.
  - Otherwise: go to RAMP and clear `div`.
- RAMP, on each `step`, for each channel independently:
  - level < target: +1.
  - level > target: −1.
  - level == target: hold.
- Level arithmetic never wraps or overshoots, because steps are ±1 toward the target.
- RAMP exit: if after the step update all three levels equal the targets, go to IDLE. The same edge registers `done`=1, `busy`=0, `ready`=1.
- `load` while `ready`=0 is ignored. Targets are not relatched and there is no queueing.
- `load` asserted during the `done` cycle is accepted normally.
- Reset values: `level_*`=0, latched targets=0, `frame_cnt`=0, `div`=0, state IDLE, `ready`=1, `busy`=0, `done`=0.
- Reset asserted mid-ramp: all registers go to reset values immediately, without waiting for a clock edge. The ramp is aborted and no `done` is issued.

## Timing
- Handshake acceptance occurs at the rising edge where `load`=1 and `ready`=1.
- `ready` and `busy` change at that same edge.
- Level updates are registered at the edge where `step`=1, i.e. the edge where `frame_cnt` goes 2^WIDTH−1 → 0. The new level is therefore valid for the whole next PWM period.
- Step spacing: STEP_DIV × 2^WIDTH cycles.
  - The first step after acceptance occurs on the STEP_DIV-th `frame_end` after acceptance.
- Ramp length is max over channels of |target − level| steps.
- `done` is high for exactly one cycle:
  - For a ramp: the cycle after the final step edge.
  - For an equal-target load: the cycle after acceptance.
- `done`, `ready`, `busy` and `level_*` are all registered outputs with no combinational paths from inputs.

## Test plan
- **Async reset:** assert `reset` between clock edges during RAMP → `level_*`=0, `ready`=1, `busy`=0, `done`=0 before the next edge. After release, `frame_cnt` restarts at 0.
- **Up-ramp** (WIDTH=4, STEP_DIV=1): from reset, load (3,0,0) at cycle 2.
  - Expect `level_r` = 1, 2, 3 at the edges where `frame_cnt` wraps, i.e. 16 cycles apart.
  - Expect `done` one cycle with `level_r`=3 and `busy` falling at the same time. G and B stay at 0.
- **Mixed up/down** (WIDTH=4, STEP_DIV=2): from (3,0,0), load (1,2,0).
  - Expect (2,1,0) after the 2nd `frame_end`, then (1,2,0) after the 4th (32 cycles later).
  - Expect one `done` pulse, then `ready`=1.
- **Load while busy:** mid-ramp toward (3,0,0), pulse `load` with (0,15,15) → ignored, `ready` stays 0, and the ramp completes at (3,0,0).
- **Equal target:** at (1,2,0) in IDLE, load (1,2,0) → `busy` never asserts, `done` is high for one cycle in the cycle after acceptance, and the levels are unchanged.
- **Back-to-back:** assert `load`=(0,0,0) during the `done` cycle of the previous ramp → accepted at that edge, and the ramp down to zero begins.
